// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch initiator. Drives the word-addressed PC into the icache,
//   captures the instruction returned one cycle later, and buffers it with its
//   PC in a small prefetch FIFO. Decode takes entries through a valid/ready
//   handshake. A redirect reloads the PC, drops the in-flight response and
//   flushes the FIFO.
//
// Ports
//   CLK             clock, rising edge
//   RST             asynchronous reset, active low
//   ic_pc           PC presented to the icache (registered)
//   ic_instr        icache instruction for the PC presented one cycle earlier
//   redirect_valid  branch/jump redirect request
//   redirect_pc     redirect target PC
//   out_valid       FIFO head holds a valid instruction
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction
//   out_pc          PC of the head instruction
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [WIDTH-1:0] ic_pc,
    input  logic [WIDTH-1:0] ic_instr,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    // Wide enough for count + inflight without overflow (up to DEPTH + 1).
    localparam int CW = AW + 2;

    logic [WIDTH-1:0] pc_reg;
    logic             inflight;
    logic [WIDTH-1:0] inflight_pc;

    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             pop;
    logic             push;
    logic             issue;
    logic [CW-1:0]    occupancy;

    assign ic_pc     = pc_reg;
    assign out_valid = (count != '0);
    // Gated so the head reads as zero when empty, matching the reset view.
    assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;

    assign pop  = out_valid & out_ready;
    assign push = inflight & ~redirect_valid;

    // Slots committed after this edge: stored entries plus the response still
    // in flight, less the entry leaving. pop implies count >= 1, so no underflow.
    assign occupancy = count + CW'(inflight) - CW'(pop);
    assign issue     = ~redirect_valid & (occupancy < CW'(DEPTH));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_reg      <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc_reg   <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            pc_reg      <= pc_reg + WIDTH'(1);
            inflight    <= 1'b1;
            inflight_pc <= pc_reg;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= ic_instr;
                mem_pc[wr_ptr]    <= inflight_pc;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] ic_pc;
    logic [31:0] ic_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'd0)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ic_pc          (ic_pc),
        .ic_instr       (ic_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 CLK = ~CLK;

    // icache model: one-cycle registered lookup, instr = pc + 100
    always @(posedge CLK) ic_instr <= ic_pc + 32'd100;

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_icpc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench in "cycle 0": first cycle after reset release.
    task automatic do_reset();
        RST            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] wrap_seq [4];
        logic        prev_hold;
        logic [31:0] prev_pc, prev_instr;
        logic        rdy;
        int          accepted;

        // Backpressure vectors from reset: ready low until the FIFO is full
        // and PC stalled at 4, then ready high.
        tbl[0]  = '{1'b0, 1'b0, 32'd0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'd0, 32'd1};
        tbl[2]  = '{1'b0, 1'b1, 32'd0, 32'd2};
        tbl[3]  = '{1'b0, 1'b1, 32'd0, 32'd3};
        tbl[4]  = '{1'b0, 1'b1, 32'd0, 32'd4};
        tbl[5]  = '{1'b0, 1'b1, 32'd0, 32'd4};
        tbl[6]  = '{1'b1, 1'b1, 32'd0, 32'd4};
        tbl[7]  = '{1'b1, 1'b1, 32'd1, 32'd5};
        tbl[8]  = '{1'b1, 1'b1, 32'd2, 32'd6};
        tbl[9]  = '{1'b1, 1'b1, 32'd3, 32'd7};
        tbl[10] = '{1'b1, 1'b1, 32'd4, 32'd8};
        tbl[11] = '{1'b1, 1'b1, 32'd5, 32'd9};

        // Reset values and streaming with ready held high
        do_reset();
        chk("reset_ic_pc", ic_pc, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_instr", out_instr, 32'd0);
        chk("reset_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("stream_valid", {31'd0, out_valid}, {31'd0, c >= 2});
            chk("stream_icpc", ic_pc, 32'(c));
            if (c >= 2) begin
                chk("stream_pc", out_pc, 32'(c - 2));
                chk("stream_instr", out_instr, 32'(c - 2 + 100));
            end
            step();
        end

        // Backpressure table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            out_ready = tbl[i].rdy;
            chk("bp_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
            chk("bp_icpc", ic_pc, tbl[i].exp_icpc);
            if (tbl[i].exp_valid) begin
                chk("bp_pc", out_pc, tbl[i].exp_pc);
                chk("bp_instr", out_instr, tbl[i].exp_pc + 32'd100);
            end
            step();
        end

        // Reset mid-stream with the FIFO full
        out_ready = 1'b0;
        repeat (6) step();
        chk("prerst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_icpc", ic_pc, 32'd0);
        chk("midrst_pc", out_pc, 32'd0);
        chk("midrst_instr", out_instr, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("restart_valid", {31'd0, out_valid}, {31'd0, c >= 2});
            if (c >= 2) chk("restart_pc", out_pc, 32'(c - 2));
            step();
        end

        // Redirect with 3 entries buffered and one fetch in flight
        do_reset();
        repeat (4) step();
        chk("redir_pre_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_icpc", ic_pc, 32'h40);
        step();
        chk("redir_gap_valid", {31'd0, out_valid}, 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("redir_valid", {31'd0, out_valid}, 32'd1);
            chk("redir_pc", out_pc, 32'h40 + 32'(k));
            chk("redir_instr", out_instr, 32'h40 + 32'(k) + 32'd100);
            step();
        end

        // Held redirect (last value wins) into a PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234;
        step();
        chk("hold1_valid", {31'd0, out_valid}, 32'd0);
        chk("hold1_icpc", ic_pc, 32'h1234);
        redirect_pc = 32'hFFFF_FFFE;
        step();
        chk("hold2_valid", {31'd0, out_valid}, 32'd0);
        chk("hold2_icpc", ic_pc, 32'hFFFF_FFFE);
        redirect_valid = 1'b0;
        step();
        chk("wrap_gap_valid", {31'd0, out_valid}, 32'd0);
        step();
        wrap_seq[0] = 32'hFFFF_FFFE;
        wrap_seq[1] = 32'hFFFF_FFFF;
        wrap_seq[2] = 32'h0;
        wrap_seq[3] = 32'h1;
        for (int k = 0; k < 4; k++) begin
            chk("wrap_valid", {31'd0, out_valid}, 32'd1);
            chk("wrap_pc", out_pc, wrap_seq[k]);
            chk("wrap_instr", out_instr, wrap_seq[k] + 32'd100);
            step();
        end

        // Random ready against a stream model: accepted PCs must count up
        // from RESET_PC, instr = pc + 100, head frozen while stalled.
        do_reset();
        exp_pc     = 32'd0;
        prev_hold  = 1'b0;
        prev_pc    = '0;
        prev_instr = '0;
        accepted   = 0;
        for (int c = 0; c < 200; c++) begin
            rdy = 1'($urandom_range(0, 1));
            if (prev_hold) begin
                chk("rand_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("rand_hold_pc", out_pc, prev_pc);
                chk("rand_hold_instr", out_instr, prev_instr);
            end
            if (out_valid) begin
                chk("rand_instr", out_instr, out_pc + 32'd100);
                if (rdy) begin
                    chk("rand_pc", out_pc, exp_pc);
                    exp_pc = exp_pc + 32'd1;
                    accepted++;
                end
            end
            prev_hold  = out_valid & ~rdy;
            prev_pc    = out_pc;
            prev_instr = out_instr;
            out_ready  = rdy;
            step();
        end
        chk("rand_progress", {31'd0, accepted >= 60}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
